trajectory_line_raster: RTL and testbench
=========================================

# trajectory_line_raster

Parametrised trajectory-line generator for the VGA pipeline. On each frame-start request it rasterises a straight line from an anchor point (the clamp) to a target point (the aimed ball position) with a sequential Bresenham engine, and stores per-row X spans in an internal table. During the visible frame it answers per-pixel draw requests from that table, with optional dashed mode. Its output feeds the object mux like any other `*_DR` request.

## Interface
- `LINE_ROWS`, 64: number of span-table rows; rows at or beyond `ytop+LINE_ROWS` are clipped.
- `DASH_LOG2`, 2: dash length is 2^DASH_LOG2 rows.
- `COORD_W`, 11: signed coordinate width.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a new rasterisation; the top level drives it at start of frame.
- `anchorX`, `anchorY`  in  COORD_W signed  line start point, sampled on `start`.
- `targetX`, `targetY`  in  COORD_W signed  line end point, sampled on `start`.
- `line_en`  in  1  master draw enable.
- `dash_en`  in  1  dashed-line mode.
- `pixelX`, `pixelY`  in  COORD_W signed  current VGA pixel.
- `busy`  out  1  high while in CLEAR or TRACE.
- `line_DR`  out  1  registered draw request for the pixel presented one cycle earlier.

## Operation
- States: IDLE, CLEAR, TRACE, READY. Reset enters IDLE.
- IDLE/READY with `start`=1: latch x0=anchorX, y0=anchorY, x1=targetX, y1=targetY, and ytop=min(y0,y1), then go to CLEAR.
- CLEAR: invalidate one table row per cycle, rows 0..LINE_ROWS-1. Lasts exactly LINE_ROWS cycles, then go to TRACE.
- TRACE setup, done on entry:
  - dx=|x1-x0|, dy=-|y1-y0|.
  - sx=sign(x1-x0), sy=sign(y1-y0), with +1 when the difference is zero.
  - err=dx+dy.
  - Internal widths: COORD_W+2 bits signed for dx, dy, err and e2.
- TRACE, one point per cycle with current point (x,y):
  - Record step: r=y-ytop. If 0≤r<LINE_ROWS: if row r is invalid, set min=max=x and mark it valid; otherwise min=min(min,x), max=max(max,x).
  - If (x,y)==(x1,y1), go to READY.
  - Otherwise e2=2·err. If e2≥dy: err+=dy, x+=sx. If e2≤dx: err+=dx, y+=sy.
  - Point count = max(dx,|dy|)+1. Points outside the row window are stepped through but not recorded.
- READY: the table is held. Draw rule:
  - `line_DR`=1 iff `line_en`, and r=pixelY-ytop satisfies 0≤r<LINE_ROWS, and row r is valid, and min≤pixelX≤max.
  - In addition, if `dash_en`=1, bit DASH_LOG2 of r must be 0.
- `start` during CLEAR or TRACE aborts the current operation, relatches the inputs and restarts CLEAR from row 0.
- `line_DR` is forced to 0 in IDLE, CLEAR and TRACE. A frame never shows a partial line.
- Degenerate line (anchor == target): exactly one point; one row with min=max=x0.

## Timing
- Reset values: `line_DR`=0, `busy`=0, state IDLE, all rows invalid.
- Reset asserted mid-operation returns to IDLE immediately and invalidates the table. The line stays undrawn until the next `start`.
- `start` sampled at edge k:
  - `busy`=1 from edge k.
  - CLEAR occupies edges k+1..k+LINE_ROWS.
  - TRACE occupies the next max(dx,|dy|)+1 edges.
  - `busy` drops and READY is entered on the edge after the last recorded point.
- Total busy time = LINE_ROWS + max(dx,|dy|) + 1 cycles.
- Draw path latency is exactly 1 cycle: `line_DR` at edge t+1 reflects `pixelX`/`pixelY`/`line_en`/`dash_en` at edge t.
- `start` arriving in the same cycle the trace completes is a restart; READY is not entered.

## Test plan
- Vertical line, LINE_ROWS=64. anchor (288,64), target (288,100), `start` -> `busy` high for 64+37=101 cycles, then:
  - pixel (288,80) -> `line_DR`=1.
  - (289,80) -> 0.
  - (288,101) -> 0.
- Horizontal line. (100,50)->(120,50):
  - pixels (100,50), (110,50), (120,50) -> 1.
  - (121,50) and (110,51) -> 0.
  - `busy` length 64+21.
- Diagonal line. (0,0)->(10,10):
  - (5,5) -> 1.
  - (6,5), (4,5) -> 0.
  - with `line_en`=0, (5,5) -> 0.
- Clipping. (0,0)->(0,100):
  - (0,63) -> 1.
  - (0,64) -> 0.
  - trace still runs 101 points before READY.
- Dashed mode. `dash_en`=1, (0,0)->(0,20):
  - rows 0-3 and 8-11 -> 1.
  - rows 4-7 and 12-15 -> 0.
  - with `dash_en`=0, all rows 0-20 -> 1.
- Restart and reset.
  - Second `start` mid-TRACE with target (50,50): final table matches a clean run to (50,50), and no stale rows remain.
  - `reset` mid-CLEAR: `busy`=0 and `line_DR`=0 next cycle; no draw until a new `start` completes.

Source files
------------

// File: rtl/trajectory_line_raster.sv
// Bresenham trajectory-line rasteriser with per-row X span table.
// Rasterises on start, answers per-pixel draw requests once READY.
module trajectory_line_raster #(
  parameter int LINE_ROWS = 64,
  parameter int DASH_LOG2 = 2,
  parameter int COORD_W   = 11
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] anchorX,
  input  logic signed [COORD_W-1:0] anchorY,
  input  logic signed [COORD_W-1:0] targetX,
  input  logic signed [COORD_W-1:0] targetY,
  input  logic                      line_en,
  input  logic                      dash_en,
  input  logic signed [COORD_W-1:0] pixelX,
  input  logic signed [COORD_W-1:0] pixelY,
  output logic                      busy,
  output logic                      line_DR
);

  localparam int EW = COORD_W + 2;
  localparam int RW = (LINE_ROWS > 1) ? $clog2(LINE_ROWS) : 1;
  localparam logic signed [EW-1:0] ROWS_S = EW'(LINE_ROWS);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    TRACE,
    READY
  } state_t;

  state_t state_q, state_d;

  logic [RW-1:0]             clr_q;
  logic signed [COORD_W-1:0] x1_q, y1_q, ytop_q;
  logic signed [COORD_W-1:0] x_q, y_q;
  logic signed [EW-1:0]      dx_q, dy_q, err_q;
  logic                      sx_neg_q, sy_neg_q;

  logic [LINE_ROWS-1:0]      valid_q;
  logic signed [COORD_W-1:0] min_q [LINE_ROWS];
  logic signed [COORD_W-1:0] max_q [LINE_ROWS];

  // setup terms computed straight from the inputs being latched
  logic signed [EW-1:0] ddx, ddy, adx, ady;

  always_comb begin
    ddx = EW'(targetX) - EW'(anchorX);
    ddy = EW'(targetY) - EW'(anchorY);
    adx = ddx[EW-1] ? -ddx : ddx;
    ady = ddy[EW-1] ? -ddy : ddy;
  end

  logic                      at_end;
  logic signed [EW-1:0]      e2, err_n;
  logic                      step_x, step_y;
  logic signed [COORD_W-1:0] x_n, y_n;
  logic signed [EW-1:0]      rr;
  logic                      in_win;
  logic [RW-1:0]             ridx;
  logic                      rec_en;

  always_comb begin
    at_end = (x_q == x1_q) && (y_q == y1_q);
    e2     = err_q <<< 1;
    step_x = (e2 >= dy_q);
    step_y = (e2 <= dx_q);
    err_n  = err_q;
    if (step_x) err_n = err_n + dy_q;
    if (step_y) err_n = err_n + dx_q;
    x_n = x_q;
    if (step_x) x_n = sx_neg_q ? x_q - 1'b1 : x_q + 1'b1;
    y_n = y_q;
    if (step_y) y_n = sy_neg_q ? y_q - 1'b1 : y_q + 1'b1;
    rr     = EW'(y_q) - EW'(ytop_q);
    in_win = (rr >= 0) && (rr < ROWS_S);
    ridx   = rr[RW-1:0];
    rec_en = (state_q == TRACE) && in_win;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = IDLE;
      CLEAR: if (clr_q == RW'(LINE_ROWS - 1)) state_d = TRACE;
      TRACE: if (at_end) state_d = READY;
      READY: state_d = READY;
      default: state_d = IDLE;
    endcase
    // a start in any state is a (re)start
    if (start) state_d = CLEAR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_q    <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      ytop_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else if (start) begin
      clr_q    <= '0;
      x1_q     <= targetX;
      y1_q     <= targetY;
      ytop_q   <= (anchorY < targetY) ? anchorY : targetY;
      x_q      <= anchorX;
      y_q      <= anchorY;
      dx_q     <= adx;
      dy_q     <= -ady;
      err_q    <= adx - ady;
      sx_neg_q <= ddx[EW-1];
      sy_neg_q <= ddy[EW-1];
    end else if (state_q == CLEAR) begin
      clr_q <= clr_q + 1'b1;
    end else if (state_q == TRACE && !at_end) begin
      x_q   <= x_n;
      y_q   <= y_n;
      err_q <= err_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  valid_q <= '0;
    else if (state_q == CLEAR)  valid_q[clr_q] <= 1'b0;
    else if (rec_en)            valid_q[ridx] <= 1'b1;
  end

  // span storage needs no reset; the valid bit qualifies it
  always_ff @(posedge clk) begin
    if (rec_en) begin
      if (!valid_q[ridx] || x_q < min_q[ridx]) min_q[ridx] <= x_q;
      if (!valid_q[ridx] || x_q > max_q[ridx]) max_q[ridx] <= x_q;
    end
  end

  logic signed [EW-1:0] pr;
  logic                 pin;
  logic [RW-1:0]        pidx;
  logic                 dr_d;

  always_comb begin
    pr   = EW'(pixelY) - EW'(ytop_q);
    pin  = (pr >= 0) && (pr < ROWS_S);
    pidx = pr[RW-1:0];
    dr_d = 1'b0;
    if (state_q == READY && !start && line_en && pin)
      dr_d = valid_q[pidx]
          && (pixelX >= min_q[pidx])
          && (pixelX <= max_q[pidx])
          && !(dash_en && pr[DASH_LOG2]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) line_DR <= 1'b0;
    else       line_DR <= dr_d;
  end

  assign busy = (state_q == CLEAR) || (state_q == TRACE);

endmodule

// File: tb/tb_trajectory_line_raster.sv
// Directed bench for trajectory_line_raster.
// Hand-computed spans, busy lengths, dash and restart cases.
module tb_trajectory_line_raster;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [10:0] anchorX, anchorY, targetX, targetY;
  logic               line_en, dash_en;
  logic signed [10:0] pixelX, pixelY;
  logic               busy, line_DR;

  int total = 0;
  int bad = 0;

  trajectory_line_raster #(
    .LINE_ROWS(64),
    .DASH_LOG2(2),
    .COORD_W(11)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .anchorX(anchorX),
    .anchorY(anchorY),
    .targetX(targetX),
    .targetY(targetY),
    .line_en(line_en),
    .dash_en(dash_en),
    .pixelX(pixelX),
    .pixelY(pixelY),
    .busy(busy),
    .line_DR(line_DR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fire(input int ax, input int ay, input int tx, input int ty);
    @(negedge clk);
    anchorX = 11'(ax);
    anchorY = 11'(ay);
    targetX = 11'(tx);
    targetY = 11'(ty);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int exp);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, exp);
  endtask

  task automatic pix(input string tag, input int x, input int y, input int exp);
    @(negedge clk);
    pixelX = 11'(x);
    pixelY = 11'(y);
    @(negedge clk);
    chk(tag, int'(line_DR), exp);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    anchorX = '0; anchorY = '0; targetX = '0; targetY = '0;
    line_en = 1'b1;
    dash_en = 1'b0;
    pixelX = '0; pixelY = '0;
    repeat (3) @(negedge clk);
    chk("rst_dr", int'(line_DR), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    pix("idle_dr", 0, 0, 0);

    // vertical
    fire(288, 64, 288, 100);
    wait_idle("vert_busy", 101);
    pix("vert_in", 288, 80, 1);
    pix("vert_right", 289, 80, 0);
    pix("vert_below", 288, 101, 0);
    pix("vert_top", 288, 64, 1);
    pix("vert_bot", 288, 100, 1);

    // horizontal
    fire(100, 50, 120, 50);
    wait_idle("horz_busy", 85);
    pix("horz_l", 100, 50, 1);
    pix("horz_m", 110, 50, 1);
    pix("horz_r", 120, 50, 1);
    pix("horz_past", 121, 50, 0);
    pix("horz_row", 110, 51, 0);

    // diagonal
    fire(0, 0, 10, 10);
    wait_idle("diag_busy", 75);
    pix("diag_on", 5, 5, 1);
    pix("diag_r", 6, 5, 0);
    pix("diag_l", 4, 5, 0);
    pix("diag_end", 10, 10, 1);
    line_en = 1'b0;
    pix("diag_off", 5, 5, 0);
    line_en = 1'b1;

    // clipping
    fire(0, 0, 0, 100);
    wait_idle("clip_busy", 165);
    pix("clip_63", 0, 63, 1);
    pix("clip_64", 0, 64, 0);

    // dashed
    fire(0, 0, 0, 20);
    wait_idle("dash_busy", 85);
    dash_en = 1'b1;
    for (int y = 0; y < 16; y++)
      pix($sformatf("dash_r%0d", y), 0, y, ((y / 4) % 2 == 0) ? 1 : 0);
    dash_en = 1'b0;
    for (int y = 0; y <= 20; y++)
      pix($sformatf("solid_r%0d", y), 0, y, 1);
    pix("solid_r21", 0, 21, 0);

    // restart mid-trace
    pixelX = 11'(0);
    pixelY = 11'(5);
    fire(0, 0, 0, 40);
    repeat (70) @(negedge clk);
    chk("rs_busy1", int'(busy), 1);
    chk("rs_dr_busy", int'(line_DR), 0);
    fire(0, 0, 50, 50);
    wait_idle("rs_busy2", 115);
    pix("rs_d0", 0, 0, 1);
    pix("rs_d20", 20, 20, 1);
    pix("rs_d50", 50, 50, 1);
    pix("rs_stale20", 0, 20, 0);
    pix("rs_stale40", 0, 40, 0);
    pix("rs_off", 21, 20, 0);
    pix("rs_r51", 50, 51, 0);

    // reset mid-clear
    fire(0, 0, 0, 10);
    pixelX = 11'(0);
    pixelY = 11'(5);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rc_busy", int'(busy), 0);
    chk("rc_dr", int'(line_DR), 0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("rc_busy_after", int'(busy), 0);
    pix("rc_nodraw", 0, 5, 0);
    fire(0, 0, 0, 10);
    wait_idle("rc_busy2", 75);
    pix("rc_draw", 0, 5, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
